conv_load_weights_ddr_ctrl: RTL and testbench
=============================================

Name: conv_load_weights_ddr_ctrl

Overview:
- Sequencer that loads one layer's convolution weights from DDR (MIG-style 512-bit word interface) into the on-chip weight buffer.
- On a start pulse it computes the layer's weight-word count and splits it into burst read commands.
- It tracks returned words and issues buffer write strobes with sequential buffer addresses, then pulses a finish flag.
- Sits between the layer controller (start/finish) and the DDR command/read-data path plus the weight buffer.

Parameters:
MAX_BURST, 32, maximum words per DDR read command (1..65535)
ADR_STRIDE, 8, DDR address increment per 512-bit word
OF_PER_WORD_M0, 32, output channels packed per word in mode 0
OF_PER_WORD_M1, 64, output channels packed per word in mode 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
conv_load_weights  in  1  start pulse; sampled only in IDLE
ddr_cmd_ready  in  1  DDR command FIFO can accept a command
ddr_rd_data_valid  in  1  one 512-bit read word is present this cycle
weights_layer_base_ddr_adr_rd_init  in  32  layer weight base DDR address
mode_init  in  4  packing mode; 1 selects OF_PER_WORD_M1, any other value selects OF_PER_WORD_M0
nif_mult_k_mult_k_init  in  32  input channels times K times K
of_init  in  16  output channel count
weights_word_ddr_en_rd  out  1  word consumed from DDR this cycle
weights_word_ddr_adr_rd  out  32  DDR address of the word consumed
load_weights_ddr_base_adr  out  32  command start address
load_weights_ddr_length  out  16  command length in words
valid_load_weights_ddr_cmd  out  1  command issued this cycle
valid_load_weights  out  1  read data accepted for the buffer this cycle
weights_word_buf_en_wt  out  1  weight buffer write enable
weights_word_buf_adr_wt  out  16  weight buffer write address
conv_load_weights_fin  out  1  one-cycle done pulse
state_conv_load_weights  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset: FSM goes to IDLE and all counters and registers clear. Every output is 0 during reset and in IDLE.
- Reset mid-operation aborts to IDLE. No finish pulse is issued; outstanding DDR data is ignored.
- FSM states are IDLE, CALC, CMD, DATA, DONE.
- IDLE: when conv_load_weights=1, latch all *_init inputs and go to CALC. In any other state the start input is ignored.
- CALC (1 cycle):
  - groups = ceil(of_init / OF_PER_WORD).
  - total = nif_mult_k_mult_k_init * groups, truncated to 32 bits.
  - Clear issued and received counters; next_adr = base.
  - If total = 0, go to DONE; otherwise go to CMD.
- CMD:
  - load_weights_ddr_base_adr = next_adr.
  - load_weights_ddr_length = min(total - issued, MAX_BURST).
  - Both values are stable throughout CMD.
  - valid_load_weights_ddr_cmd = ddr_cmd_ready, combinational, only in CMD. When it is high, go to DATA on the next edge, with burst_cnt = length.
  - Without ddr_cmd_ready, stay in CMD indefinitely.
- DATA:
  - valid_load_weights = ddr_rd_data_valid, combinational, only in DATA.
  - On each valid cycle, in the same cycle:
    - weights_word_buf_en_wt = 1.
    - weights_word_buf_adr_wt = received[15:0], which wraps modulo 2^16.
    - weights_word_ddr_en_rd = 1.
    - weights_word_ddr_adr_rd = base + received*ADR_STRIDE.
  - The counters advance at the clock edge.
  - When the last word of the burst is received:
    - issued += length and next_adr += length*ADR_STRIDE.
    - If issued = total, go to DONE; else go back to CMD.
  - ddr_rd_data_valid outside DATA is ignored.
- DONE: conv_load_weights_fin = 1 for exactly one cycle, then IDLE.
- state_conv_load_weights is 1 in CALC, CMD, DATA and DONE.
- Commands never overlap: each burst must complete before the next command.
- Address arithmetic wraps modulo 2^32.

Test Plan:
- Reset, then start with mode=0, nif=18, of=128, base=0, MAX_BURST=32:
  - Three commands with (adr, length) = (0, 32), (256, 32), (512, 8).
  - 72 buffer writes at addresses 0..71.
  - weights_word_ddr_adr_rd steps 0, 8, ..., 568.
  - One fin pulse after the 72nd write; state then drops.
- Same run with ddr_rd_data_valid toggling every cycle and ddr_cmd_ready low for 10 cycles after each command:
  - Writes occur only on valid cycles.
  - valid_load_weights_ddr_cmd is asserted only while ready=1.
  - Final write count is 72.
- mode=1, nif=9, of=100 -> groups=2, total=18: a single command of length 18, buffer addresses 0..17, then fin.
- nif=0 -> no command issued; fin pulses in the cycle after CALC; state is high for exactly 2 cycles.
- Assert reset during the second burst:
  - All outputs go to 0 immediately; no fin pulse.
  - A new start then begins again from buffer address 0.
- Pulse start while busy -> ignored; the transfer count and addresses of the ongoing load are unchanged.

Source files
------------

// File: rtl/conv_load_weights_ddr_ctrl.sv
// conv_load_weights_ddr_ctrl
// Loads one layer's convolution weights from DDR into the on-chip weight
// buffer. A start pulse latches the layer geometry. The sequencer then works
// out how many 512-bit words the layer needs and requests them in bursts of
// at most MAX_BURST words. Each returned word is forwarded as one buffer write
// at a sequential address. A one-cycle finish pulse closes the load.
//
// Handshakes:
//   - A command is issued in CMD when ddr_cmd_ready is high. That same cycle
//     shows valid_load_weights_ddr_cmd, and the FSM moves to DATA on the next
//     edge.
//   - A read word is consumed in DATA when ddr_rd_data_valid is high. That
//     same cycle shows the buffer write strobe and address. The counters
//     advance on the next edge.
//   - Neither input is looked at in any other state.
module conv_load_weights_ddr_ctrl #(
    parameter int MAX_BURST      = 32,
    parameter int ADR_STRIDE     = 8,
    parameter int OF_PER_WORD_M0 = 32,
    parameter int OF_PER_WORD_M1 = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        conv_load_weights,
    input  logic        ddr_cmd_ready,
    input  logic        ddr_rd_data_valid,
    input  logic [31:0] weights_layer_base_ddr_adr_rd_init,
    input  logic [3:0]  mode_init,
    input  logic [31:0] nif_mult_k_mult_k_init,
    input  logic [15:0] of_init,
    output logic        weights_word_ddr_en_rd,
    output logic [31:0] weights_word_ddr_adr_rd,
    output logic [31:0] load_weights_ddr_base_adr,
    output logic [15:0] load_weights_ddr_length,
    output logic        valid_load_weights_ddr_cmd,
    output logic        valid_load_weights,
    output logic        weights_word_buf_en_wt,
    output logic [15:0] weights_word_buf_adr_wt,
    output logic        conv_load_weights_fin,
    output logic        state_conv_load_weights
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_CMD  = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);
    localparam logic [15:0] MAX_BURST_H = 16'(MAX_BURST);
    localparam logic [31:0] STRIDE_W    = 32'(ADR_STRIDE);
    localparam logic [16:0] OPW_M0      = 17'(OF_PER_WORD_M0);
    localparam logic [16:0] OPW_M1      = 17'(OF_PER_WORD_M1);

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [3:0]  mode_q, mode_d;
    logic [31:0] nif_q, nif_d;
    logic [15:0] of_q, of_d;
    logic [31:0] total_q, total_d;
    logic [31:0] issued_q, issued_d;
    logic [31:0] received_q, received_d;
    logic [31:0] next_adr_q, next_adr_d;
    logic [15:0] len_q, len_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;

    logic [16:0] of_ext;
    logic [16:0] groups;
    logic [31:0] total_calc;
    logic [31:0] remaining;
    logic [15:0] cmd_len;
    logic [31:0] issued_after;
    logic        in_cmd;
    logic        word_take;

    // Layer size in words: output-channel groups times nif*K*K, 32-bit wrap.
    always_comb begin
        of_ext = {1'b0, of_q};
        if (mode_q == 4'd1) begin
            groups = (of_ext + (OPW_M1 - 17'd1)) / OPW_M1;
        end else begin
            groups = (of_ext + (OPW_M0 - 17'd1)) / OPW_M0;
        end
        total_calc = nif_q * {15'd0, groups};
    end

    // Length of the next command, clipped to the maximum burst size.
    always_comb begin
        remaining    = total_q - issued_q;
        cmd_len      = (remaining > MAX_BURST_W) ? MAX_BURST_H : remaining[15:0];
        issued_after = issued_q + {16'd0, len_q};
        in_cmd       = (state_q == S_CMD);
        word_take    = (state_q == S_DATA) && ddr_rd_data_valid;
    end

    // Next-state and counter updates.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        mode_d      = mode_q;
        nif_d       = nif_q;
        of_d        = of_q;
        total_d     = total_q;
        issued_d    = issued_q;
        received_d  = received_q;
        next_adr_d  = next_adr_q;
        len_d       = len_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (conv_load_weights) begin
                    base_d  = weights_layer_base_ddr_adr_rd_init;
                    mode_d  = mode_init;
                    nif_d   = nif_mult_k_mult_k_init;
                    of_d    = of_init;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                total_d    = total_calc;
                issued_d   = 32'd0;
                received_d = 32'd0;
                next_adr_d = base_q;
                state_d    = (total_calc == 32'd0) ? S_DONE : S_CMD;
            end
            S_CMD: begin
                if (ddr_cmd_ready) begin
                    len_d       = cmd_len;
                    burst_cnt_d = cmd_len;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (ddr_rd_data_valid) begin
                    received_d  = received_q + 32'd1;
                    burst_cnt_d = burst_cnt_q - 16'd1;
                    if (burst_cnt_q == 16'd1) begin
                        issued_d   = issued_after;
                        next_adr_d = next_adr_q + ({16'd0, len_q} * STRIDE_W);
                        state_d    = (issued_after == total_q) ? S_DONE : S_CMD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any load in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= 32'd0;
            mode_q      <= 4'd0;
            nif_q       <= 32'd0;
            of_q        <= 16'd0;
            total_q     <= 32'd0;
            issued_q    <= 32'd0;
            received_q  <= 32'd0;
            next_adr_q  <= 32'd0;
            len_q       <= 16'd0;
            burst_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            mode_q      <= mode_d;
            nif_q       <= nif_d;
            of_q        <= of_d;
            total_q     <= total_d;
            issued_q    <= issued_d;
            received_q  <= received_d;
            next_adr_q  <= next_adr_d;
            len_q       <= len_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Output decode: everything is zero outside the state that owns it.
    always_comb begin
        valid_load_weights_ddr_cmd = in_cmd && ddr_cmd_ready;
        load_weights_ddr_base_adr  = in_cmd ? next_adr_q : 32'd0;
        load_weights_ddr_length    = in_cmd ? cmd_len : 16'd0;
        valid_load_weights         = word_take;
        weights_word_buf_en_wt     = word_take;
        weights_word_buf_adr_wt    = word_take ? received_q[15:0] : 16'd0;
        weights_word_ddr_en_rd     = word_take;
        weights_word_ddr_adr_rd    = word_take ? (base_q + received_q * STRIDE_W) : 32'd0;
        conv_load_weights_fin      = (state_q == S_DONE);
        state_conv_load_weights    = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_conv_load_weights_ddr_ctrl.sv
// tb_conv_load_weights_ddr_ctrl
// Table of load scenarios with hand-computed totals, applied in a loop against
// a small DDR responder. A scoreboard queue holds the buffer addresses the
// load should produce.
module tb_conv_load_weights_ddr_ctrl;

    logic        clk;
    logic        reset;
    logic        conv_load_weights;
    logic        ddr_cmd_ready;
    logic        ddr_rd_data_valid;
    logic [31:0] weights_layer_base_ddr_adr_rd_init;
    logic [3:0]  mode_init;
    logic [31:0] nif_mult_k_mult_k_init;
    logic [15:0] of_init;
    logic        weights_word_ddr_en_rd;
    logic [31:0] weights_word_ddr_adr_rd;
    logic [31:0] load_weights_ddr_base_adr;
    logic [15:0] load_weights_ddr_length;
    logic        valid_load_weights_ddr_cmd;
    logic        valid_load_weights;
    logic        weights_word_buf_en_wt;
    logic [15:0] weights_word_buf_adr_wt;
    logic        conv_load_weights_fin;
    logic        state_conv_load_weights;

    conv_load_weights_ddr_ctrl dut (
        .clk                                (clk),
        .reset                              (reset),
        .conv_load_weights                  (conv_load_weights),
        .ddr_cmd_ready                      (ddr_cmd_ready),
        .ddr_rd_data_valid                  (ddr_rd_data_valid),
        .weights_layer_base_ddr_adr_rd_init (weights_layer_base_ddr_adr_rd_init),
        .mode_init                          (mode_init),
        .nif_mult_k_mult_k_init             (nif_mult_k_mult_k_init),
        .of_init                            (of_init),
        .weights_word_ddr_en_rd             (weights_word_ddr_en_rd),
        .weights_word_ddr_adr_rd            (weights_word_ddr_adr_rd),
        .load_weights_ddr_base_adr          (load_weights_ddr_base_adr),
        .load_weights_ddr_length            (load_weights_ddr_length),
        .valid_load_weights_ddr_cmd         (valid_load_weights_ddr_cmd),
        .valid_load_weights                 (valid_load_weights),
        .weights_word_buf_en_wt             (weights_word_buf_en_wt),
        .weights_word_buf_adr_wt            (weights_word_buf_adr_wt),
        .conv_load_weights_fin              (conv_load_weights_fin),
        .state_conv_load_weights            (state_conv_load_weights)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic any_output();
        return weights_word_ddr_en_rd | (|weights_word_ddr_adr_rd) |
               (|load_weights_ddr_base_adr) | (|load_weights_ddr_length) |
               valid_load_weights_ddr_cmd | valid_load_weights |
               weights_word_buf_en_wt | (|weights_word_buf_adr_wt) |
               conv_load_weights_fin | state_conv_load_weights;
    endfunction

    typedef struct {
        logic [3:0]  mode;
        logic [31:0] nif;
        logic [15:0] of_cnt;
        logic [31:0] base;
        logic        toggle;     // data valid only every other cycle
        int          gap;        // cycles of cmd_ready low after each command
        int          restart_cyc;// cycle of a start pulse while busy (0 = none)
        int          abort_at;   // assert reset after this many writes (0 = none)
        int          exp_total;
        int          exp_cmds;
        int          exp_writes;
        int          exp_last_len;
        int          exp_fins;
        int          exp_busy;   // busy cycles expected (0 = not checked)
    } vec_t;

    vec_t vecs[11];

    task automatic run_vec(input int idx, input vec_t v);
        int          pending  = 0;
        int          issued   = 0;
        int          cmds     = 0;
        int          writes   = 0;
        int          fins     = 0;
        int          busy     = 0;
        int          last_len = 0;
        int          gap_cnt  = 0;
        int          exp_len;
        logic        phase    = 1'b0;
        logic        done     = 1'b0;
        logic [31:0] exp_adr;
        exp_q.delete();

        @(negedge clk);
        weights_layer_base_ddr_adr_rd_init = v.base;
        mode_init                          = v.mode;
        nif_mult_k_mult_k_init             = v.nif;
        of_init                            = v.of_cnt;
        conv_load_weights                  = 1'b1;

        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            conv_load_weights = (v.restart_cyc != 0) && (cyc == v.restart_cyc);
            ddr_cmd_ready     = (gap_cnt == 0);
            phase             = ~phase;
            ddr_rd_data_valid = (pending > 0) && (!v.toggle || phase);
            #1;
            if (state_conv_load_weights) busy++;
            if (valid_load_weights_ddr_cmd) begin
                exp_len = v.exp_total - issued;
                if (exp_len > 32) exp_len = 32;
                exp_adr = v.base + 32'(issued) * 32'd8;
                check("cmd_only_when_ready", 32'(ddr_cmd_ready), 32'd1);
                check("cmd_adr", load_weights_ddr_base_adr, exp_adr);
                check("cmd_len", 32'(load_weights_ddr_length), 32'(exp_len));
                for (int k = 0; k < int'(load_weights_ddr_length); k++) begin
                    exp_q.push_back(32'(issued + k));
                end
                pending  += int'(load_weights_ddr_length);
                issued   += int'(load_weights_ddr_length);
                last_len  = int'(load_weights_ddr_length);
                cmds++;
                gap_cnt   = v.gap;
            end else if (gap_cnt > 0) begin
                gap_cnt--;
            end
            check("wr_only_on_valid", 32'(weights_word_buf_en_wt), 32'(ddr_rd_data_valid));
            if (ddr_rd_data_valid) begin
                check("valid_load_weights", 32'(valid_load_weights), 32'd1);
                check("ddr_en_rd", 32'(weights_word_ddr_en_rd), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_adr = exp_q.pop_front();
                    check("buf_adr", 32'(weights_word_buf_adr_wt), {16'd0, exp_adr[15:0]});
                    check("ddr_adr_rd", weights_word_ddr_adr_rd, v.base + exp_adr * 32'd8);
                end
                writes++;
                pending--;
            end
            if (conv_load_weights_fin) begin
                fins++;
                check("writes_at_fin", 32'(writes), 32'(v.exp_writes));
                done = 1'b1;
            end
            if (v.abort_at != 0 && writes == v.abort_at && !done) begin
                reset             = 1'b1;
                ddr_cmd_ready     = 1'b1;
                ddr_rd_data_valid = 1'b1;
                #1;
                check("outs_zero_in_reset", 32'(any_output()), 32'd0);
                for (int r = 0; r < 3; r++) begin
                    @(negedge clk);
                    check("no_fin_after_abort", 32'(conv_load_weights_fin | state_conv_load_weights), 32'd0);
                end
                reset             = 1'b0;
                ddr_cmd_ready     = 1'b0;
                ddr_rd_data_valid = 1'b0;
                done              = 1'b1;
            end
        end
        if (!done) begin
            $display("FAIL timeout: vec %0d got no fin within 4000 cycles, expected fin", idx);
            n_checks++;
        end

        // One more cycle: the FSM must have returned to IDLE.
        @(negedge clk);
        conv_load_weights = 1'b0;
        ddr_cmd_ready     = 1'b0;
        ddr_rd_data_valid = 1'b0;
        #1;
        check("idle_after", 32'(state_conv_load_weights | conv_load_weights_fin), 32'd0);
        check("cmd_count", 32'(cmds), 32'(v.exp_cmds));
        check("write_count", 32'(writes), 32'(v.exp_writes));
        check("last_len", 32'(last_len), 32'(v.exp_last_len));
        check("fin_count", 32'(fins), 32'(v.exp_fins));
        if (v.exp_busy != 0) check("busy_cycles", 32'(busy), 32'(v.exp_busy));
    endtask

    initial begin
        //          mode  nif    of    base          tog gap rst abrt tot cmd wr  last fin busy
        vecs[0]  = '{4'd0, 32'd18, 16'd128, 32'h0,        1'b0, 0,  0,  0,  72, 3, 72, 8,  1, 0};
        vecs[1]  = '{4'd0, 32'd18, 16'd128, 32'h0,        1'b1, 10, 0,  0,  72, 3, 72, 8,  1, 0};
        vecs[2]  = '{4'd1, 32'd9,  16'd100, 32'h0,        1'b0, 0,  0,  0,  18, 1, 18, 18, 1, 0};
        vecs[3]  = '{4'd0, 32'd0,  16'd128, 32'h0,        1'b0, 0,  0,  0,  0,  0, 0,  0,  1, 2};
        vecs[4]  = '{4'd0, 32'd18, 16'd128, 32'h0,        1'b0, 0,  20, 0,  72, 3, 72, 8,  1, 0};
        vecs[5]  = '{4'd0, 32'd18, 16'd128, 32'h0,        1'b0, 0,  0,  40, 72, 2, 40, 32, 0, 0};
        vecs[6]  = '{4'd1, 32'd9,  16'd100, 32'h1000,     1'b0, 0,  0,  0,  18, 1, 18, 18, 1, 0};
        vecs[7]  = '{4'd0, 32'd3,  16'd32,  32'hFFFF_FFF8, 1'b0, 0,  0,  0,  3,  1, 3,  3,  1, 0};
        vecs[8]  = '{4'd2, 32'd5,  16'd33,  32'h40,       1'b0, 0,  0,  0,  10, 1, 10, 10, 1, 0};
        vecs[9]  = '{4'd0, 32'd32, 16'd32,  32'h0,        1'b0, 0,  0,  0,  32, 1, 32, 32, 1, 0};
        vecs[10] = '{4'd0, 32'd33, 16'd1,   32'h200,      1'b1, 3,  0,  0,  33, 2, 33, 1,  1, 0};

        reset                              = 1'b1;
        conv_load_weights                  = 1'b0;
        ddr_cmd_ready                      = 1'b1;
        ddr_rd_data_valid                  = 1'b1;
        weights_layer_base_ddr_adr_rd_init = 32'h0;
        mode_init                          = 4'd0;
        nif_mult_k_mult_k_init             = 32'd0;
        of_init                            = 16'd0;
        #1;
        check("reset_outs_zero", 32'(any_output()), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset             = 1'b0;
        ddr_cmd_ready     = 1'b0;
        ddr_rd_data_valid = 1'b0;
        #1;
        check("idle_outs_zero", 32'(any_output()), 32'd0);

        // Stray data and ready in IDLE must not produce any activity.
        @(negedge clk);
        ddr_cmd_ready     = 1'b1;
        ddr_rd_data_valid = 1'b1;
        #1;
        check("idle_ignores_inputs", 32'(any_output()), 32'd0);
        ddr_cmd_ready     = 1'b0;
        ddr_rd_data_valid = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
